// File: rtl/mac_stop_mult_lanes.sv
// rtl/mac_stop_mult_lanes.sv - multi-lane matrix product stage with 2-entry output queue
// Walks A (MxK) and B (KxN), emitting LANES products per beat ahead of the accumulator.
module mac_stop_mult_lanes #(
  parameter int M     = 2,
  parameter int K     = 2,
  parameter int N     = 4,
  parameter int LANES = 2,
  parameter int DW    = 16,
  localparam int PW   = 2 * DW,
  localparam int AW_M = (M > 1) ? $clog2(M) : 1,
  localparam int AW_K = (K > 1) ? $clog2(K) : 1,
  localparam int AW_N = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic                  hold,
  output logic                  busy,
  output logic                  done,
  output logic                  a_re,
  output logic [AW_M-1:0]       a_row_addr,
  output logic [AW_K-1:0]       a_col_addr,
  output logic                  b_re,
  output logic [AW_K-1:0]       b_row_addr,
  output logic [AW_N-1:0]       b_col_addr,
  input  logic [DW-1:0]         data_in_a,
  input  logic [LANES*DW-1:0]   data_in_b,
  output logic                  prod_valid,
  input  logic                  prod_ready,
  output logic [LANES*PW-1:0]   prod_data,
  output logic [AW_M-1:0]       prod_row,
  output logic [AW_N-1:0]       prod_col,
  output logic [AW_K-1:0]       prod_k,
  output logic                  prod_last_k,
  output logic                  prod_last
);

  localparam int G    = N / LANES;
  localparam int AW_G = (G > 1) ? $clog2(G) : 1;
  localparam int EW   = LANES * PW + AW_M + AW_N + AW_K + 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state;
  logic              mode;
  logic [AW_M-1:0]   r;
  logic [AW_G-1:0]   g;
  logic [AW_K-1:0]   k;
  logic [AW_N-1:0]   col_base;
  logic              last_beat;
  logic              issue;
  logic              pop;
  logic              push;

  logic              inflight;
  logic [AW_M-1:0]   fl_r;
  logic [AW_N-1:0]   fl_col;
  logic [AW_K-1:0]   fl_k;
  logic              fl_last;

  logic [1:0]        cnt;
  logic [EW-1:0]     q0;
  logic [EW-1:0]     q1;
  logic [EW-1:0]     new_e;
  logic [LANES*PW-1:0] prod_vec;

  function automatic logic [PW-1:0] ext(input logic [DW-1:0] v, input logic s);
    return {{(PW - DW){s & v[DW-1]}}, v};
  endfunction

  assign col_base  = AW_N'(32'(g) * LANES);
  assign last_beat = (r == AW_M'(M - 1)) && (g == AW_G'(G - 1)) && (k == AW_K'(K - 1));
  assign pop       = (cnt != 2'd0) && prod_ready;
  assign push      = inflight;

  // Reserve a queue slot for every read in flight so a stalled consumer never loses a beat.
  assign issue = (state == RUN) && !hold &&
                 (({1'b0, cnt} + {2'b0, inflight} - {2'b0, pop}) < 3'd2);

  assign a_re       = issue;
  assign b_re       = issue;
  assign a_row_addr = r;
  assign a_col_addr = k;
  assign b_row_addr = k;
  assign b_col_addr = col_base;
  assign busy       = (state != IDLE);
  assign prod_valid = (cnt != 2'd0);
  assign {prod_data, prod_row, prod_col, prod_k, prod_last_k, prod_last} = q0;

  // Truncating a PW x PW product to PW bits gives the exact DW x DW result in either mode.
  always_comb begin
    prod_vec = '0;
    for (int i = 0; i < LANES; i++) begin
      prod_vec[i*PW +: PW] = ext(data_in_a, mode) * ext(data_in_b[i*DW +: DW], mode);
    end
  end

  assign new_e = {prod_vec, fl_r, fl_col, fl_k, (fl_k == AW_K'(K - 1)), fl_last};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      mode     <= 1'b0;
      r        <= '0;
      g        <= '0;
      k        <= '0;
      done     <= 1'b0;
      inflight <= 1'b0;
      fl_r     <= '0;
      fl_col   <= '0;
      fl_k     <= '0;
      fl_last  <= 1'b0;
      cnt      <= 2'd0;
      q0       <= '0;
      q1       <= '0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      if (issue) begin
        fl_r    <= r;
        fl_col  <= col_base;
        fl_k    <= k;
        fl_last <= last_beat;
      end

      case (state)
        IDLE: begin
          if (start) begin
            mode  <= is_signed;
            r     <= '0;
            g     <= '0;
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (issue) begin
            if (last_beat) state <= DRAIN;
            if (k == AW_K'(K - 1)) begin
              k <= '0;
              if (g == AW_G'(G - 1)) begin
                g <= '0;
                r <= (r == AW_M'(M - 1)) ? '0 : r + 1'b1;
              end else begin
                g <= g + 1'b1;
              end
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (pop && prod_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) q0 <= new_e;
          else             q1 <= new_e;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          q0  <= q1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            q0 <= new_e;
          end else begin
            q0 <= q1;
            q1 <= new_e;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_stop_mult_lanes.sv
// tb/tb_mac_stop_mult_lanes.sv - scoreboard bench for mac_stop_mult_lanes
// Expected beats are queued at job start and retired as the DUT pops its output queue.
module tb_mac_stop_mult_lanes;

  localparam int M = 2, K = 2, N = 4, LANES = 2, DW = 8;
  localparam int PW = 2 * DW, AW_M = 1, AW_K = 1, AW_N = 2;

  logic clk, resetn, start, is_signed, hold, prod_ready;
  logic busy, done, a_re, b_re, prod_valid, prod_last_k, prod_last;
  logic [AW_M-1:0] a_row_addr, prod_row;
  logic [AW_K-1:0] a_col_addr, b_row_addr, prod_k;
  logic [AW_N-1:0] b_col_addr, prod_col;
  logic [DW-1:0] data_in_a;
  logic [LANES*DW-1:0] data_in_b;
  logic [LANES*PW-1:0] prod_data;
  logic [63:0] outs;

  mac_stop_mult_lanes #(.M(M), .K(K), .N(N), .LANES(LANES), .DW(DW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .is_signed(is_signed), .hold(hold),
    .busy(busy), .done(done), .a_re(a_re), .a_row_addr(a_row_addr), .a_col_addr(a_col_addr),
    .b_re(b_re), .b_row_addr(b_row_addr), .b_col_addr(b_col_addr),
    .data_in_a(data_in_a), .data_in_b(data_in_b), .prod_valid(prod_valid),
    .prod_ready(prod_ready), .prod_data(prod_data), .prod_row(prod_row), .prod_col(prod_col),
    .prod_k(prod_k), .prod_last_k(prod_last_k), .prod_last(prod_last)
  );

  assign outs = 64'({busy, done, a_re, b_re, a_row_addr, a_col_addr, b_row_addr, b_col_addr,
                     prod_valid, prod_data, prod_row, prod_col, prod_k, prod_last_k, prod_last});

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [LANES*PW-1:0] data;
    int row, col, k;
    bit last_k, last;
  } beat_t;

  beat_t sb[$];
  beat_t e;
  int checks = 0, failures = 0;
  logic [DW-1:0] mem_a [M][K];
  logic [DW-1:0] mem_b [K][N];

  int n_are, are_early, n_done, done_c, hold_lo = -1, hold_hi = -1, hold_viol;
  bit rand_start = 0;
  logic [31:0] are_m, vld_m;
  logic [LANES*PW-1:0] first_data;

  // Synchronous memories: data appears the cycle after the read enable.
  always @(posedge clk) begin
    if (a_re) begin
      data_in_a <= mem_a[a_row_addr][a_col_addr];
      for (int i = 0; i < LANES; i++) data_in_b[i*DW +: DW] <= mem_b[b_row_addr][32'(b_col_addr) + i];
    end
  end

  function automatic logic [PW-1:0] ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit s);
    int av, bv;
    logic [31:0] p;
    av = s ? int'($signed(a)) : int'(a);
    bv = s ? int'($signed(b)) : int'(b);
    p = av * bv;
    return p[PW-1:0];
  endfunction

  task automatic push_expected(input bit s);
    beat_t b;
    for (int r = 0; r < M; r++)
      for (int g = 0; g < N / LANES; g++)
        for (int k = 0; k < K; k++) begin
          for (int i = 0; i < LANES; i++) b.data[i*PW +: PW] = ref_mul(mem_a[r][k], mem_b[k][g*LANES+i], s);
          b.row = r; b.col = g * LANES; b.k = k;
          b.last_k = (k == K - 1);
          b.last = (r == M - 1) && (g == N / LANES - 1) && (k == K - 1);
          sb.push_back(b);
        end
  endtask

  always @(negedge clk) begin
    if (resetn && prod_valid && prod_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL beat_unexpected got row=%0d col=%0d k=%0d, required no beat", prod_row, prod_col, prod_k);
      end else begin
        e = sb.pop_front();
        if ({prod_data, prod_row, prod_col, prod_k, prod_last_k, prod_last} !==
            {e.data, AW_M'(e.row), AW_N'(e.col), AW_K'(e.k), e.last_k, e.last}) begin
          failures++;
          $display("FAIL beat got data=%h r=%0d c=%0d k=%0d lk=%0b l=%0b, required data=%h r=%0d c=%0d k=%0d lk=%0b l=%0b",
                   prod_data, prod_row, prod_col, prod_k, prod_last_k, prod_last,
                   e.data, e.row, e.col, e.k, e.last_k, e.last);
        end
      end
    end
  end

  task automatic randomize_mem();
    for (int r = 0; r < M; r++) for (int k = 0; k < K; k++) mem_a[r][k] = DW'($urandom);
    for (int k = 0; k < K; k++) for (int c = 0; c < N; c++) mem_b[k][c] = DW'($urandom);
  endtask

  // mode 0: ready always high, 1: ready low for cycles 1..10, 2: random ready
  task automatic run_job(input bit sgn, input int mode);
    bit prev_busy, prev_lastpop, got_first;
    push_expected(sgn);
    n_are = 0; are_early = 0; n_done = 0; done_c = -1; hold_viol = 0;
    are_m = 0; vld_m = 0; first_data = 0; got_first = 0;
    prev_busy = 0; prev_lastpop = 1;
    @(posedge clk); #1;
    start = 1; is_signed = sgn; hold = 0; prod_ready = (mode != 1);
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      start = (rand_start && prev_busy && !prev_lastpop) ? 1'($urandom_range(0, 1)) : 1'b0;
      hold = (c >= hold_lo) && (c <= hold_hi);
      case (mode)
        0: prod_ready = 1;
        1: prod_ready = (c > 10);
        default: prod_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (a_re) begin
        n_are++;
        if (c <= 10) are_early++;
        if (c < 32) are_m[c] = 1'b1;
        if (hold) hold_viol++;
      end
      if (prod_valid && c < 32) vld_m[c] = 1'b1;
      if (prod_valid && !got_first) begin first_data = prod_data; got_first = 1; end
      prev_busy = busy;
      prev_lastpop = prod_valid && prod_ready && prod_last;
      if (done) begin n_done++; done_c = c; break; end
    end
    @(posedge clk); #1;
    start = 0; hold = 0;
    repeat (3) begin @(negedge clk); if (done) n_done++; end
    if (done_c < 0) begin
      checks++; failures++;
      $display("FAIL job_timeout got no done within 400 cycles, required done");
    end
  endtask

  task automatic test_reset();
    resetn = 0; start = 0; is_signed = 0; hold = 0; prod_ready = 0;
    data_in_a = 0; data_in_b = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (outs !== 64'd0) begin failures++; $display("FAIL reset_outputs got %h, required 0", outs); end
    resetn = 1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || prod_valid !== 1'b0) begin
      failures++; $display("FAIL reset_idle got busy=%b valid=%b, required 0 0", busy, prod_valid);
    end
  endtask

  task automatic test_basic();
    mem_a[0][0] = 1; mem_a[0][1] = 2; mem_a[1][0] = 3; mem_a[1][1] = 4;
    mem_b[0][0] = 5; mem_b[0][1] = 6; mem_b[0][2] = 7;  mem_b[0][3] = 8;
    mem_b[1][0] = 9; mem_b[1][1] = 10; mem_b[1][2] = 11; mem_b[1][3] = 12;
    run_job(0, 0);
    checks++; if (are_m !== 32'h0000_01FE) begin failures++; $display("FAIL basic_are_cycles got %h, required 000001fe", are_m); end
    checks++; if (vld_m !== 32'h0000_07F8) begin failures++; $display("FAIL basic_valid_cycles got %h, required 000007f8", vld_m); end
    checks++; if (done_c != 11) begin failures++; $display("FAIL basic_done_cycle got %0d, required 11", done_c); end
    checks++; if (n_done != 1) begin failures++; $display("FAIL basic_done_count got %0d, required 1", n_done); end
    checks++; if (first_data !== 32'h0006_0005) begin failures++; $display("FAIL basic_first_beat got %h, required 00060005", first_data); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL basic_leftover got %0d, required 0", sb.size()); end
  endtask

  task automatic test_signed();
    randomize_mem();
    mem_a[0][0] = 8'hFF; mem_b[0][0] = 8'h02; mem_b[0][1] = 8'h80;
    run_job(1, 0);
    checks++; if (first_data !== 32'h0080_FFFE) begin failures++; $display("FAIL signed_lanes got %h, required 0080fffe", first_data); end
    run_job(0, 0);
    checks++; if (first_data !== 32'h7F80_01FE) begin failures++; $display("FAIL unsigned_lanes got %h, required 7f8001fe", first_data); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL signed_leftover got %0d, required 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    randomize_mem();
    run_job(0, 1);
    checks++; if (are_early != 2) begin failures++; $display("FAIL bp_early_issues got %0d, required 2", are_early); end
    checks++; if (n_are != 8) begin failures++; $display("FAIL bp_total_issues got %0d, required 8", n_are); end
    checks++; if (n_done != 1 || sb.size() != 0) begin
      failures++; $display("FAIL bp_completion got done=%0d left=%0d, required 1 0", n_done, sb.size());
    end
  endtask

  task automatic test_hold();
    randomize_mem();
    hold_lo = 3; hold_hi = 5;
    run_job(1, 0);
    hold_lo = -1; hold_hi = -1;
    checks++; if (hold_viol != 0) begin failures++; $display("FAIL hold_issue got %0d issues under hold, required 0", hold_viol); end
    checks++; if (n_are != 8) begin failures++; $display("FAIL hold_total got %0d, required 8", n_are); end
    checks++; if (done_c != 14) begin failures++; $display("FAIL hold_done_cycle got %0d, required 14", done_c); end
  endtask

  task automatic test_random();
    int bad = 0;
    rand_start = 1;
    for (int j = 0; j < 1000; j++) begin
      randomize_mem();
      run_job(1'($urandom_range(0, 1)), 2);
      checks++;
      if (n_done != 1 || sb.size() != 0) begin
        failures++; bad++;
        if (bad < 5) $display("FAIL random_job%0d got done=%0d left=%0d, required 1 0", j, n_done, sb.size());
        sb.delete();
      end
    end
    rand_start = 0;
  endtask

  task automatic test_reset_drain();
    randomize_mem();
    push_expected(0);
    @(posedge clk); #1;
    start = 1; is_signed = 0; prod_ready = 1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start = 0;
      prod_ready = (c <= 8);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || prod_valid !== 1'b1 || a_re !== 1'b0) begin
      failures++; $display("FAIL drain_setup got busy=%b valid=%b are=%b, required 1 1 0", busy, prod_valid, a_re);
    end
    resetn = 0;
    #1;
    checks++;
    if (outs !== 64'd0) begin failures++; $display("FAIL drain_reset_outputs got %h, required 0", outs); end
    sb.delete();
    @(posedge clk); #1;
    resetn = 1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL drain_no_done got done=%b busy=%b, required 0 0", done, busy); end
    run_job(0, 0);
    checks++;
    if (done_c != 11 || n_done != 1 || sb.size() != 0) begin
      failures++; $display("FAIL drain_clean_job got done_c=%0d done=%0d left=%0d, required 11 1 0", done_c, n_done, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_backpressure();
    test_hold();
    test_random();
    test_reset_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

endmodule
